// File: rtl/puf_eval_ctrl_if.sv
// puf_eval_ctrl_if: host command/response signals and PUF array drive signals
interface puf_eval_ctrl_if #(
  parameter int N_PUF  = 16,
  parameter int CHAL_W = 128
);
  logic              start;
  logic [CHAL_W-1:0] challenge;
  logic              busy;
  logic              done;
  logic [N_PUF-1:0]  response;
  logic [N_PUF-1:0]  stable;
  logic [CHAL_W-1:0] puf_challenge;
  logic              puf_reset;
  logic              puf_launch;
  logic [N_PUF-1:0]  puf_resp;
  modport master (
    output start, challenge, puf_resp,
    input  busy, done, response, stable, puf_challenge, puf_reset, puf_launch
  );
  modport slave (
    input  start, challenge, puf_resp,
    output busy, done, response, stable, puf_challenge, puf_reset, puf_launch
  );
endinterface

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences NUM_EVAL precharge/launch/settle/capture rounds and majority-votes the PUF array
module puf_eval_ctrl #(
  parameter int N_PUF         = 16,
  parameter int CHAL_W        = 128,
  parameter int NUM_EVAL      = 5,
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input logic            clk,
  input logic            reset,
  puf_eval_ctrl_if.slave bus
);
  localparam int CW = $clog2(NUM_EVAL + 1);
  localparam int TW = $clog2((RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, PRE, LAUNCH, SETTLE, CAPTURE, FINISH} state_t;
  state_t            r_state;
  logic [TW-1:0]     r_tmr;
  logic [7:0]        r_idx;
  logic [CW-1:0]     r_ones [N_PUF];
  logic [CW-1:0]     w_ones [N_PUF];
  logic [N_PUF-1:0]  r_ref, r_agree, w_agree, w_resp;
  logic              r_busy, r_done, r_puf_reset, r_puf_launch;
  logic [N_PUF-1:0]  r_response, r_stable;
  logic [CHAL_W-1:0] r_puf_challenge;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.response      = r_response;
  assign bus.stable        = r_stable;
  assign bus.puf_challenge = r_puf_challenge;
  assign bus.puf_reset     = r_puf_reset;
  assign bus.puf_launch    = r_puf_launch;
  // Counts including the current sample, so the vote is ready in the capture cycle itself
  always_comb begin
    for (int i = 0; i < N_PUF; i++) begin
      w_ones[i] = r_ones[i] + CW'(bus.puf_resp[i]);
      w_resp[i] = w_ones[i] > CW'(NUM_EVAL / 2);
    end
    w_agree = (r_idx == 8'd0) ? '1 : r_agree & ~(bus.puf_resp ^ r_ref);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_tmr           <= '0;
      r_idx           <= '0;
      r_ref           <= '0;
      r_agree         <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_response      <= '0;
      r_stable        <= '0;
      r_puf_challenge <= '0;
      r_puf_reset     <= 1'b1;
      r_puf_launch    <= 1'b0;
      for (int i = 0; i < N_PUF; i++) r_ones[i] <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_puf_challenge <= bus.challenge;
          r_idx           <= '0;
          r_tmr           <= '0;
          r_busy          <= 1'b1;
          r_state         <= PRE;
          for (int i = 0; i < N_PUF; i++) r_ones[i] <= '0;
        end
        PRE: if (r_tmr == TW'(RST_CYCLES - 1)) begin
          r_tmr        <= '0;
          r_puf_reset  <= 1'b0;
          r_puf_launch <= 1'b1;
          r_state      <= LAUNCH;
        end else r_tmr <= r_tmr + 1'b1;
        LAUNCH: r_state <= SETTLE;
        SETTLE: if (r_tmr == TW'(SETTLE_CYCLES - 1)) r_state <= CAPTURE;
          else r_tmr <= r_tmr + 1'b1;
        CAPTURE: begin
          for (int i = 0; i < N_PUF; i++) r_ones[i] <= w_ones[i];
          r_agree      <= w_agree;
          r_ref        <= (r_idx == 8'd0) ? bus.puf_resp : r_ref;
          r_tmr        <= '0;
          r_puf_reset  <= 1'b1;
          r_puf_launch <= 1'b0;
          if (r_idx == 8'(NUM_EVAL - 1)) begin
            r_response <= w_resp;
            r_stable   <= w_agree;
            r_done     <= 1'b1;
            r_state    <= FINISH;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= PRE;
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: scoreboard bench for the default and single-evaluation controller configurations
module tb_puf_eval_ctrl;
  typedef struct {
    logic [15:0] r;
    logic [15:0] s;
    int          c;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  puf_eval_ctrl_if #(.N_PUF(16), .CHAL_W(128)) a ();
  puf_eval_ctrl_if #(.N_PUF(16), .CHAL_W(128)) b ();
  puf_eval_ctrl u0 (.clk(clk), .reset(reset), .bus(a.slave));
  puf_eval_ctrl #(.NUM_EVAL(1), .SETTLE_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [4:0][15:0] mk(input logic [15:0] s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a.done) begin
      if (qa.size() == 0) chk("done_a_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        chk("response_a", a.response, e.r);
        chk("stable_a", a.stable, e.s);
        chk("done_a_cycle", cyc, e.c);
      end
    end
  end
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b.done) begin
      if (qb.size() == 0) chk("done_b_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        chk("response_b", b.response, e.r);
        chk("stable_b", b.stable, e.s);
        chk("done_b_cycle", cyc, e.c);
      end
    end
  end
  task automatic do_run(input logic [127:0] ch, input logic [4:0][15:0] seq,
                        input logic [15:0] er, es, input bit wave, input bit inject);
    int t0, rel, m;
    qa.push_back('{er, es, cyc + 61});
    a.start = 1'b1;
    a.challenge = ch;
    t0 = cyc;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      a.start = 1'b0;
      rel = cyc - t0;
      if (rel <= 60) a.puf_resp = seq[(rel - 1) / 12];
      chk("busy", a.busy, rel <= 61);
      if (wave && rel == 1) chk("puf_challenge_load", a.puf_challenge, ch);
      if (wave && rel <= 60) begin
        m = (rel - 1) % 12;
        chk("puf_reset", a.puf_reset, m < 2);
        chk("puf_launch", a.puf_launch, m >= 2);
      end
      if (inject && (rel == 20 || rel == 61)) begin
        a.start = 1'b1;
        a.challenge = ~ch;
      end
      if (inject && rel > 20) chk("puf_challenge_hold", a.puf_challenge, ch);
    end
    chk("done_a_seen", qa.size(), 0);
  endtask
  initial begin
    int t0;
    a.start = 1'b0; a.challenge = '0; a.puf_resp = '0;
    b.start = 1'b0; b.challenge = '0; b.puf_resp = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_response", a.response, 0);
    chk("rst_stable", a.stable, 0);
    chk("rst_puf_challenge", a.puf_challenge, 0);
    chk("rst_puf_reset", a.puf_reset, 1);
    chk("rst_puf_launch", a.puf_launch, 0);
    a.start = 1'b1;
    a.challenge = 128'hFEED;
    @(negedge clk);
    reset = 1'b0;
    a.start = 1'b0;
    chk("rst_start_busy", a.busy, 0);
    chk("rst_start_challenge", a.puf_challenge, 0);
    @(negedge clk);
    chk("rst_start_idle", a.busy, 0);
    do_run(128'h0123456789ABCDEF0123456789ABCDEF, mk(16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3),
           16'hA5C3, 16'hFFFF, 1'b1, 1'b0);
    do_run(128'h1, mk(16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0001), 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    do_run(128'h2, mk(16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000), 16'h0000, 16'hFFFE, 1'b0, 1'b0);
    do_run(128'hCAFE, mk(16'hFFFF, 16'h0F0F, 16'hFFFF, 16'h0F0F, 16'hFFFF), 16'hFFFF, 16'h0F0F, 1'b0, 1'b1);
    do_run(128'h3, mk(16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C), 16'h3C3C, 16'hFFFF, 1'b0, 1'b0);
    a.start = 1'b1;
    a.challenge = 128'h4;
    a.puf_resp = 16'hFFFF;
    t0 = cyc;
    for (int k = 0; k < 40 && cyc - t0 < 30; k++) begin
      @(negedge clk);
      a.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", a.busy, 0);
    chk("abort_puf_reset", a.puf_reset, 1);
    chk("abort_puf_launch", a.puf_launch, 0);
    chk("abort_response", a.response, 0);
    chk("abort_stable", a.stable, 0);
    repeat (70) @(negedge clk);
    do_run(128'h5, mk(16'h0000, 16'h8001, 16'h8001, 16'h8001, 16'h0000), 16'h8001, 16'h7FFE, 1'b0, 1'b0);
    qb.push_back('{16'hBEEF, 16'hFFFF, cyc + 6});
    b.start = 1'b1;
    b.challenge = 128'h6;
    t0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      b.start = 1'b0;
      b.puf_resp = (cyc - t0 == 5) ? 16'hBEEF : 16'h1234;
      if (cyc - t0 == 1) chk("b_puf_challenge", b.puf_challenge, 128'h6);
    end
    chk("done_b_seen", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Sequenced evaluation controller for an array of N_PUF PDL_PUF delay-line arbiter PUFs. Generalises the existing challenge/trigger mapping: parametrised PUF count and challenge width, on-chip timing of precharge, launch and settle, and NUM_EVAL repeated evaluations per challenge.
- Outputs a majority-voted response and a per-bit stability mask.
- Sits between the host/Ethernet command path and the PDL_PUF array; drives each instance's reset, both launch inputs (s1/s2), and both challenge halves.

Parameters:
- N_PUF, 16: number of PUF instances and response bits.
- CHAL_W, 128: challenge width; the lower half drives s_tp, the upper half drives s_btm.
- NUM_EVAL, 5: evaluations per challenge; must be odd, range 1..255.
- RST_CYCLES, 2: precharge cycles with puf_reset high; must be ≥1.
- SETTLE_CYCLES, 8: wait cycles after launch before capture; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request evaluation; accepted only in IDLE
- challenge  in  CHAL_W  challenge, sampled when start is accepted
- busy  out  1  high from the cycle after acceptance through the done cycle
- done  out  1  one-cycle pulse when response and stable are valid
- response  out  N_PUF  majority-voted response
- stable  out  N_PUF  1 where all NUM_EVAL samples of that bit agreed
- puf_challenge  out  CHAL_W  registered challenge to the PUF array
- puf_reset  out  1  arbiter/delay-line clear to all PUFs
- puf_launch  out  1  launch edge; drives s1 and s2 of every PUF
- puf_resp  in  N_PUF  arbiter outputs, one per PUF

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: busy=0, done=0, response=0, stable=0, puf_challenge=0, puf_reset=1, puf_launch=0, FSM=IDLE, all counters=0.
- IDLE:
  - puf_reset=1, puf_launch=0.
  - start=1 latches challenge into puf_challenge, clears the per-bit ones counters and the eval index, then moves to PRE.
- PRE: puf_reset=1, puf_launch=0 for exactly RST_CYCLES cycles, then LAUNCH.
- LAUNCH: puf_reset=0, puf_launch=1 for one cycle, then SETTLE.
- SETTLE: puf_launch stays 1 for exactly SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE (one cycle, puf_launch=1):
  - Sample puf_resp and add puf_resp[i] to ones_cnt[i].
  - On the first evaluation, store the sample as the reference. On later evaluations, clear agree[i] if the sample differs from the reference.
  - If this is the last evaluation (index NUM_EVAL-1), go to FINISH; otherwise increment the index and go to PRE.
- FINISH (one cycle):
  - response[i] = (ones_cnt[i] > NUM_EVAL/2), integer division.
  - stable[i] = agree[i].
  - done=1 and busy=1 in this cycle; next state is IDLE.
- Output holding: response and stable hold until the next FINISH or reset. They are not cleared on start.
- Counter width: ones_cnt is wide enough to hold NUM_EVAL. It cannot overflow.
- Timing (cycle 0 is the start-accept cycle):
  - Per-evaluation period P = RST_CYCLES + SETTLE_CYCLES + 2.
  - done is asserted at cycle NUM_EVAL*P + 1.
  - With defaults, P=12 and done is at cycle 61.
  - Within an evaluation: launch rises RST_CYCLES+1 cycles after PRE entry; capture occurs SETTLE_CYCLES+1 cycles after launch rises.
- Boundary conditions:
  - start while busy (including the FINISH cycle) is ignored, with no queuing. A challenge change mid-run does not affect puf_challenge.
  - reset mid-run aborts the run: no done pulse, response and stable are cleared, and the next start behaves as a fresh run.
  - start and reset asserted in the same cycle: reset wins and start is dropped.
  - NUM_EVAL=1: response equals the single sample and stable is all ones.
  - puf_resp is sampled only in CAPTURE; values in other states are don't-care.

Test Plan:
- Defaults, puf_resp held at 16'hA5C3, start at cycle 0 → busy rises at cycle 1, done pulses only at cycle 61, response=16'hA5C3, stable=16'hFFFF.
- puf_resp[0] sequence 1,1,0,0,1 across the five captures, other bits 0 → response=16'h0001, stable=16'hFFFE. Sequence 0,1,0,1,0 → response=16'h0000, stable=16'hFFFE.
- Waveform check, defaults, challenge=128'h0123...CDEF:
  - puf_challenge updates at cycle 1.
  - puf_reset high for cycles 1-2; puf_launch high for cycles 3-12; puf_reset high again at cycle 13.
  - The pattern repeats 5 times.
- start pulsed at cycles 20 and 61 with a different challenge → both ignored, exactly one done (cycle 61), puf_challenge unchanged. A start at cycle 62 is accepted.
- reset at cycle 30 → from cycle 31: busy=0, puf_reset=1, puf_launch=0, response=0, stable=0, no done. A subsequent start completes normally 61 cycles later.
- Override NUM_EVAL=1, SETTLE_CYCLES=1 → P=5, done at cycle 6, response=puf_resp sampled at cycle 5, stable=all ones.
